// File: rtl/my_store_unit.sv
// Store-side formatter and FIFO store buffer between the MEM stage and the data bus.
// Requests are lane-replicated, strobed by address, then drained to the bus in order.
module my_store_unit #(
   parameter int DEPTH = 2,
   parameter int AW    = 32
) (
   input  logic          cpu_clk,
   input  logic          cpu_rst,
   input  logic          st_valid,
   input  logic [1:0]    st_sel,
   input  logic [AW-1:0] st_addr,
   input  logic [31:0]   st_data,
   output logic          st_ready,
   output logic          st_misalign,
   output logic          busy,
   output logic          bus_wvalid,
   output logic [AW-1:0] bus_addr,
   output logic [31:0]   bus_wdata,
   output logic [3:0]    bus_we,
   input  logic          bus_wready
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

   localparam logic [1:0] SEL_B = 2'b00;
   localparam logic [1:0] SEL_H = 2'b01;
   localparam logic [1:0] SEL_W = 2'b10;

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW:0]   count_q, count_d;

   // Entry payload is split by field; address keeps only the word index.
   logic [AW-3:0] addr_mem  [DEPTH];
   logic [31:0]   wdata_mem [DEPTH];
   logic [3:0]    we_mem    [DEPTH];

   logic [31:0] fmt_wdata;
   logic [3:0]  fmt_we;
   logic        fmt_illegal;
   logic [1:0]  a;

   logic empty, full, push, pop;

   assign a = st_addr[1:0];

   always_comb begin
      fmt_wdata   = '0;
      fmt_we      = '0;
      fmt_illegal = 1'b0;
      case (st_sel)
         SEL_B: begin
            fmt_wdata = {4{st_data[7:0]}};
            fmt_we    = 4'b0001 << a;
         end
         SEL_H: begin
            fmt_wdata   = {2{st_data[15:0]}};
            fmt_we      = a[1] ? 4'b1100 : 4'b0011;
            fmt_illegal = a[0];
         end
         SEL_W: begin
            fmt_wdata   = st_data;
            fmt_we      = 4'b1111;
            fmt_illegal = (a != 2'b00);
         end
         default: begin
            fmt_illegal = 1'b1;
         end
      endcase
   end

   assign empty       = (count_q == '0);
   assign full        = (count_q == DEPTH_C);
   assign pop         = bus_wvalid & bus_wready;
   // A full buffer may still accept when its head leaves this same cycle.
   assign st_ready    = ~full | pop;
   assign st_misalign = st_valid & fmt_illegal;
   assign push        = st_valid & st_ready & ~fmt_illegal;
   assign busy        = ~empty;

   assign bus_wvalid = ~empty;
   assign bus_addr   = empty ? '0 : {addr_mem[rd_ptr_q], 2'b00};
   assign bus_wdata  = empty ? '0 : wdata_mem[rd_ptr_q];
   assign bus_we     = empty ? '0 : we_mem[rd_ptr_q];

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: outputs are masked whenever the buffer is empty.
   always_ff @(posedge cpu_clk) begin
      if (push) begin
         addr_mem[wr_ptr_q]  <= st_addr[AW-1:2];
         wdata_mem[wr_ptr_q] <= fmt_wdata;
         we_mem[wr_ptr_q]    <= fmt_we;
      end
   end

endmodule

// File: tb/tb_my_store_unit.sv
// Scoreboard bench for my_store_unit: expected bus writes are queued at acceptance
// and compared in order against the head presented on the bus.
module tb_my_store_unit;

   localparam int DEPTH = 2;
   localparam int AW    = 32;

   logic          cpu_clk = 1'b0;
   logic          cpu_rst;
   logic          st_valid;
   logic [1:0]    st_sel;
   logic [AW-1:0] st_addr;
   logic [31:0]   st_data;
   logic          st_ready;
   logic          st_misalign;
   logic          busy;
   logic          bus_wvalid;
   logic [AW-1:0] bus_addr;
   logic [31:0]   bus_wdata;
   logic [3:0]    bus_we;
   logic          bus_wready;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  we;
   } exp_t;

   exp_t exp_q[$];
   int   tests_run    = 0;
   int   tests_failed = 0;

   always #5 cpu_clk = ~cpu_clk;

   my_store_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
      .cpu_clk     (cpu_clk),
      .cpu_rst     (cpu_rst),
      .st_valid    (st_valid),
      .st_sel      (st_sel),
      .st_addr     (st_addr),
      .st_data     (st_data),
      .st_ready    (st_ready),
      .st_misalign (st_misalign),
      .busy        (busy),
      .bus_wvalid  (bus_wvalid),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_we      (bus_we),
      .bus_wready  (bus_wready)
   );

   function automatic exp_t model(input logic [1:0] sel, input logic [31:0] addr, input logic [31:0] data);
      exp_t e;
      e.addr = {addr[31:2], 2'b00};
      for (int i = 0; i < 4; i++) begin
         case (sel)
            2'd0: begin
               e.we[i] = (int'(addr[1:0]) == i);
               e.wdata[8*i +: 8] = data[7:0];
            end
            2'd1: begin
               e.we[i] = (addr[1] == (i >= 2));
               e.wdata[8*i +: 8] = data[8*(i%2) +: 8];
            end
            default: begin
               e.we[i] = 1'b1;
               e.wdata[8*i +: 8] = data[8*i +: 8];
            end
         endcase
      end
      return e;
   endfunction

   function automatic logic is_illegal(input logic [1:0] sel, input logic [31:0] addr);
      return (sel == 2'd3) || (sel == 2'd1 && addr[0]) || (sel == 2'd2 && addr[1:0] != 2'b00);
   endfunction

   task automatic push_exp(input logic [1:0] sel, input logic [31:0] addr, input logic [31:0] data);
      exp_q.push_back(model(sel, addr, data));
   endtask

   // Waits for the falling edge and checks the bus head against the scoreboard.
   task automatic sb_sample();
      exp_t e;
      @(negedge cpu_clk);
      if (!cpu_rst && bus_wvalid) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL sb_stale: bus write addr=%h data=%h we=%b, required none", bus_addr, bus_wdata, bus_we);
         end else begin
            e = exp_q[0];
            if (bus_addr !== e.addr || bus_wdata !== e.wdata || bus_we !== e.we) begin
               tests_failed++;
               $display("[TB] FAIL sb_head: got addr=%h data=%h we=%b, required addr=%h data=%h we=%b",
                        bus_addr, bus_wdata, bus_we, e.addr, e.wdata, e.we);
            end
            if (bus_wready) begin
               void'(exp_q.pop_front());
               $display("[TB] write addr=%h data=%h we=%b", bus_addr, bus_wdata, bus_we);
            end
         end
      end
   endtask

   task automatic next_cycle();
      sb_sample();
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic do_store(input logic [1:0] sel, input logic [31:0] addr, input logic [31:0] data);
      logic acc;
      int   waits;
      acc      = 1'b0;
      waits    = 0;
      st_valid = 1'b1;
      st_sel   = sel;
      st_addr  = addr;
      st_data  = data;
      while (!acc && waits < 20) begin
         sb_sample();
         if (st_ready) begin
            acc = 1'b1;
            push_exp(sel, addr, data);
         end else begin
            waits++;
         end
         @(posedge cpu_clk);
         #1;
      end
      st_valid = 1'b0;
      tests_run++;
      if (!acc) begin
         tests_failed++;
         $display("[TB] FAIL store_accept: addr=%h not accepted after %0d cycles, required acceptance", addr, waits);
      end
   endtask

   task automatic test_reset();
      cpu_rst = 1'b1; st_valid = 1'b1; st_sel = 2'd3; st_addr = '0; st_data = '0; bus_wready = 1'b0;
      #1;
      tests_run++;
      if (bus_wvalid !== 1'b0 || busy !== 1'b0 || st_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL reset_ctrl: wvalid=%b busy=%b ready=%b, required 0 0 1", bus_wvalid, busy, st_ready);
      end
      tests_run++;
      if (bus_addr !== '0 || bus_wdata !== '0 || bus_we !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_bus: addr=%h data=%h we=%b, required zeros", bus_addr, bus_wdata, bus_we);
      end
      tests_run++;
      if (st_misalign !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL reset_misalign: got %b, required 1", st_misalign);
      end
      st_sel = 2'd0;
      #1;
      tests_run++;
      if (st_misalign !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_byte_ok: got %b, required 0", st_misalign);
      end
      st_valid = 1'b0;
      repeat (2) @(posedge cpu_clk);
      @(negedge cpu_clk);
      cpu_rst = 1'b0;
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic test_byte();
      bus_wready = 1'b1;
      do_store(2'd0, 32'h0000_1003, 32'h0000_00A5);
      tests_run++;
      if (bus_wvalid !== 1'b1 || bus_addr !== 32'h0000_1000 || bus_wdata !== 32'hA5A5_A5A5 || bus_we !== 4'b1000) begin
         tests_failed++;
         $display("[TB] FAIL byte_store: wvalid=%b addr=%h data=%h we=%b, required 1 00001000 a5a5a5a5 1000",
                  bus_wvalid, bus_addr, bus_wdata, bus_we);
      end
      next_cycle();
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL byte_busy: got %b, required 0", busy);
      end
   endtask

   task automatic test_half_misalign();
      logic [1:0]  sels  [3];
      logic [31:0] addrs [3];
      sels  = '{2'd1, 2'd2, 2'd3};
      addrs = '{32'h0000_2001, 32'h0000_2006, 32'h0000_2000};
      bus_wready = 1'b1;
      do_store(2'd1, 32'h0000_2002, 32'h1234_BEEF);
      tests_run++;
      if (bus_addr !== 32'h0000_2000 || bus_wdata !== 32'hBEEF_BEEF || bus_we !== 4'b1100) begin
         tests_failed++;
         $display("[TB] FAIL half_store: addr=%h data=%h we=%b, required 00002000 beefbeef 1100", bus_addr, bus_wdata, bus_we);
      end
      next_cycle();
      for (int i = 0; i < 3; i++) begin
         st_valid = 1'b1; st_sel = sels[i]; st_addr = addrs[i]; st_data = 32'hDEAD_0000 + i;
         #1;
         tests_run++;
         if (st_misalign !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL misalign_%0d: sel=%0d addr=%h misalign=%b, required 1", i, sels[i], addrs[i], st_misalign);
         end
         next_cycle();
         st_valid = 1'b0;
         #1;
         tests_run++;
         if (busy !== 1'b0 || bus_wvalid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL misalign_nopush_%0d: busy=%b wvalid=%b, required 0 0", i, busy, bus_wvalid);
         end
      end
   endtask

   task automatic test_backpressure();
      bus_wready = 1'b0;
      do_store(2'd2, 32'h0000_0010, 32'h1111_1111);
      do_store(2'd2, 32'h0000_0014, 32'h2222_2222);
      st_valid = 1'b1; st_sel = 2'd2; st_addr = 32'h0000_0018; st_data = 32'h3333_3333;
      for (int i = 0; i < 3; i++) begin
         sb_sample();
         tests_run++;
         if (st_ready !== 1'b0 || bus_addr !== 32'h0000_0010 || bus_wdata !== 32'h1111_1111) begin
            tests_failed++;
            $display("[TB] FAIL bp_hold_%0d: ready=%b addr=%h data=%h, required 0 00000010 11111111", i, st_ready, bus_addr, bus_wdata);
         end
         @(posedge cpu_clk);
         #1;
      end
      bus_wready = 1'b1;
      #1;
      tests_run++;
      if (st_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL bp_ready_on_pop: got %b, required 1", st_ready);
      end
      sb_sample();
      if (st_ready) push_exp(2'd2, 32'h0000_0018, 32'h3333_3333);
      @(posedge cpu_clk);
      #1;
      st_valid = 1'b0;
      for (int i = 0; i < 10 && busy; i++) next_cycle();
      tests_run++;
      if (busy !== 1'b0 || exp_q.size() != 0) begin
         tests_failed++;
         $display("[TB] FAIL bp_drain: busy=%b pending=%0d, required 0 0", busy, exp_q.size());
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      bus_wready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a = 32'h20 + 32'(4 * i);
         st_valid = 1'b1; st_sel = 2'd2; st_addr = a; st_data = 32'hA0A0_A0A0 + 32'(i);
         sb_sample();
         tests_run++;
         if (st_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_ready_%0d: got %b, required 1", i, st_ready);
         end
         if (st_ready) push_exp(2'd2, a, 32'hA0A0_A0A0 + 32'(i));
         if (i > 0) begin
            tests_run++;
            if (bus_wvalid !== 1'b1 || bus_addr !== a - 32'h4 || bus_we !== 4'b1111) begin
               tests_failed++;
               $display("[TB] FAIL b2b_bus_%0d: wvalid=%b addr=%h we=%b, required 1 %h 1111", i, bus_wvalid, bus_addr, bus_we, a - 32'h4);
            end
         end
         @(posedge cpu_clk);
         #1;
      end
      st_valid = 1'b0;
      sb_sample();
      tests_run++;
      if (bus_wvalid !== 1'b1 || bus_addr !== 32'h0000_002C) begin
         tests_failed++;
         $display("[TB] FAIL b2b_last: wvalid=%b addr=%h, required 1 0000002c", bus_wvalid, bus_addr);
      end
      @(posedge cpu_clk);
      #1;
      next_cycle();
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL b2b_idle: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_reset_mid();
      bus_wready = 1'b0;
      do_store(2'd2, 32'h0000_0040, 32'h4444_4444);
      do_store(2'd0, 32'h0000_0045, 32'h0000_0055);
      #1;
      tests_run++;
      if (st_ready !== 1'b0 || busy !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL rstmid_full: ready=%b busy=%b, required 0 1", st_ready, busy);
      end
      @(negedge cpu_clk);
      #2;
      cpu_rst = 1'b1;
      #1;
      tests_run++;
      if (bus_wvalid !== 1'b0 || busy !== 1'b0 || st_ready !== 1'b1 ||
          bus_addr !== '0 || bus_wdata !== '0 || bus_we !== '0) begin
         tests_failed++;
         $display("[TB] FAIL rstmid_async: wvalid=%b busy=%b ready=%b addr=%h data=%h we=%b, required 0 0 1 zeros",
                  bus_wvalid, busy, st_ready, bus_addr, bus_wdata, bus_we);
      end
      exp_q.delete();
      @(posedge cpu_clk);
      @(negedge cpu_clk);
      cpu_rst = 1'b0;
      @(posedge cpu_clk);
      #1;
      bus_wready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sb_sample();
         tests_run++;
         if (bus_wvalid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rstmid_stale_%0d: wvalid=%b addr=%h, required 0", i, bus_wvalid, bus_addr);
         end
         @(posedge cpu_clk);
         #1;
      end
   endtask

   task automatic test_random();
      int          cnt;
      int          r;
      logic        ill, exp_ready, do_push, do_pop;
      cnt = 0;
      for (int it = 0; it < 300; it++) begin
         r = $urandom_range(0, 9);
         st_sel     = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         st_valid   = ($urandom_range(0, 3) != 0);
         st_addr    = $urandom;
         st_data    = $urandom;
         bus_wready = $urandom_range(0, 1) == 1;
         ill        = is_illegal(st_sel, st_addr);
         exp_ready  = (cnt < DEPTH) || (cnt > 0 && bus_wready);
         do_pop     = (cnt > 0) && bus_wready;
         sb_sample();
         tests_run++;
         if (st_misalign !== (st_valid & ill)) begin
            tests_failed++;
            $display("[TB] FAIL rnd_misalign_%0d: sel=%0d addr=%h got %b, required %b", it, st_sel, st_addr, st_misalign, st_valid & ill);
         end
         tests_run++;
         if (st_ready !== exp_ready || busy !== (cnt != 0)) begin
            tests_failed++;
            $display("[TB] FAIL rnd_flow_%0d: ready=%b busy=%b, required %b %b (count %0d)", it, st_ready, busy, exp_ready, cnt != 0, cnt);
         end
         do_push = st_valid && exp_ready && !ill;
         if (do_push) push_exp(st_sel, st_addr, st_data);
         cnt = cnt + int'(do_push) - int'(do_pop);
         @(posedge cpu_clk);
         #1;
      end
      st_valid   = 1'b0;
      bus_wready = 1'b1;
      for (int i = 0; i < 10 && busy; i++) next_cycle();
      tests_run++;
      if (busy !== 1'b0 || exp_q.size() != 0) begin
         tests_failed++;
         $display("[TB] FAIL rnd_drain: busy=%b pending=%0d, required 0 0", busy, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_byte();
      test_half_misalign();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
